// File: rtl/emg_frame_scheduler_pkg.sv
// Shared types, defaults and helpers for the EMG slot schedulers.
package emg_frame_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam int DEF_CHANNELS = 128;
    localparam int DEF_DW       = 8;
    localparam int DEF_PERIOD_W = 16;

    // Bits needed to represent value (at least 1).
    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        while (v > 0) begin
            n = n + 1;
            v = v >> 1;
        end
        if (n == 0) n = 1;
        return n;
    endfunction

endpackage

// File: rtl/emg_frame_scheduler_period_timer.sv
// Free-running period counter with synchronous clear and an equal-to-limit flag.
module period_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc)
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign hit = (count_q == limit);

endmodule

// File: rtl/emg_frame_scheduler.sv
// Pulls one frame of CHANNELS samples per period tick and issues them in strict
// channel order to the encoding slot, flagging ticks that land inside a frame.
module emg_frame_scheduler
    import emg_frame_scheduler_pkg::*;
#(
    parameter  int CHANNELS = DEF_CHANNELS,
    parameter  int DW       = DEF_DW,
    parameter  int PERIOD_W = DEF_PERIOD_W,
    localparam int CW       = clogb2(CHANNELS - 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [PERIOD_W-1:0]  period,
    input  logic                 overrun_clr,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 en_out,
    output logic signed [DW-1:0] data_out,
    output logic [CW-1:0]        ch_idx,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 overrun
);

    state_t               state_q, state_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic                 s_ready_q, s_ready_d;
    logic                 en_q, en_d;
    logic signed [DW-1:0] data_q, data_d;
    logic [CW-1:0]        ch_idx_q, ch_idx_d;
    logic                 frame_start_q, frame_start_d;
    logic                 frame_done_q, frame_done_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;

    logic hs;
    logic last;
    logic tick;
    logic tmr_clr;
    logic ovr_set;

    assign hs   = s_ready_q & s_valid;
    assign last = (ch_q == CW'(CHANNELS - 1));

    period_timer #(.W(PERIOD_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .inc   (state_q != ST_IDLE),
        .limit (period_q),
        .hit   (tick)
    );

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        ch_d     = ch_q;
        tmr_clr  = 1'b0;
        ovr_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (run) begin
                    state_d  = ST_STREAM;
                    period_d = period;
                end
            end
            ST_STREAM: begin
                if (hs)
                    ch_d = last ? '0 : ch_q + CW'(1);
                if (hs && last) begin
                    if (tick) begin
                        tmr_clr  = 1'b1;
                        period_d = period;
                    end else if (run) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                        tmr_clr = 1'b1;
                    end
                end else if (tick) begin
                    // Tick inside a frame: dropped, frame keeps streaming.
                    ovr_set = 1'b1;
                    tmr_clr = 1'b1;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    state_d  = ST_STREAM;
                    tmr_clr  = 1'b1;
                    period_d = period;
                end else if (!run) begin
                    state_d = ST_IDLE;
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_clr = 1'b1;
            end
        endcase

        s_ready_d     = (state_d == ST_STREAM);
        busy_d        = (state_d != ST_IDLE);
        en_d          = hs;
        data_d        = hs ? s_data : data_q;
        ch_idx_d      = hs ? ch_q : ch_idx_q;
        frame_start_d = hs && (ch_q == '0);
        frame_done_d  = hs && last;
        overrun_d     = ovr_set | (overrun_q & ~overrun_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            period_q      <= '0;
            ch_q          <= '0;
            s_ready_q     <= 1'b0;
            en_q          <= 1'b0;
            data_q        <= '0;
            ch_idx_q      <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            ch_q          <= ch_d;
            s_ready_q     <= s_ready_d;
            en_q          <= en_d;
            data_q        <= data_d;
            ch_idx_q      <= ch_idx_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign en_out      = en_q;
    assign data_out    = data_q;
    assign ch_idx      = ch_idx_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_emg_frame_scheduler.sv
// Directed bench for emg_frame_scheduler with CHANNELS=4.
module tb_emg_frame_scheduler;

    localparam int CH = 4;
    localparam int DW = 8;
    localparam int PW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 run;
    logic [PW-1:0]        period;
    logic                 overrun_clr;
    logic signed [DW-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 en_out;
    logic signed [DW-1:0] data_out;
    logic [1:0]           ch_idx;
    logic                 frame_start;
    logic                 frame_done;
    logic                 busy;
    logic                 overrun;

    int checks = 0;
    int errors = 0;
    int feed_n;

    logic          o_ready, o_en, o_fs, o_fd, o_busy, o_ovr, hs;
    logic [1:0]    o_ch;
    logic [DW-1:0] o_data;

    emg_frame_scheduler #(.CHANNELS(CH), .DW(DW), .PERIOD_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .period      (period),
        .overrun_clr (overrun_clr),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .en_out      (en_out),
        .data_out    (data_out),
        .ch_idx      (ch_idx),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // One cycle: capture outputs mid-cycle, then advance the sample source on a handshake.
    task automatic cyc();
        @(negedge clk);
        o_ready = s_ready;
        o_en    = en_out;
        o_fs    = frame_start;
        o_fd    = frame_done;
        o_busy  = busy;
        o_ovr   = overrun;
        o_ch    = ch_idx;
        o_data  = data_out;
        hs      = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (hs) begin
            feed_n = feed_n + 1;
            s_data = DW'(8'h40 + feed_n);
        end
    endtask

    task automatic start_test(input logic [PW-1:0] p);
        rst = 1'b1;
        run = 1'b0;
        s_valid = 1'b0;
        overrun_clr = 1'b0;
        period = p;
        feed_n = 0;
        s_data = 8'sh40;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b1;
        s_valid = 1'b1;
        overrun_clr = 1'b0;
        period = 16'd5;
        feed_n = 0;
        s_data = 8'sh40;
        @(posedge clk);
        #1;
        cyc();
        cyc();
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b expected 0", o_ready); end
        checks++;
        if ({o_en, o_fs, o_fd} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {o_en, o_fs, o_fd}); end
        checks++;
        if ({o_busy, o_ovr} !== 2'b00) begin errors++; $display("FAIL reset_busy_ovr: got %b expected 00", {o_busy, o_ovr}); end
        checks++;
        if ({o_ch, o_data} !== 10'd0) begin errors++; $display("FAIL reset_ch_data: got ch=%0d data=%h expected 0/00", o_ch, o_data); end
        run = 1'b0;
        rst = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({o_ready, o_busy} !== 2'b00) begin errors++; $display("FAIL idle_no_run: got ready/busy=%b expected 00", {o_ready, o_busy}); end
    endtask

    task automatic test_frame();
        logic [1:0] exp_ch;
        int n_str, first_rdy, first_fs, second_fs, first_fd;
        logic saw_ovr;
        start_test(16'd9);
        run = 1'b1;
        s_valid = 1'b1;
        exp_ch = 2'd0;
        n_str = 0; first_rdy = -1; first_fs = -1; second_fs = -1; first_fd = -1;
        saw_ovr = 1'b0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (o_ready && first_rdy < 0) first_rdy = i;
            if (o_ovr) saw_ovr = 1'b1;
            if (o_en) begin
                checks++;
                if (o_ch !== exp_ch) begin errors++; $display("FAIL frame_ch cyc%0d: got %0d expected %0d", i, o_ch, exp_ch); end
                checks++;
                if ({o_fs, o_fd} !== {exp_ch == 2'd0, exp_ch == 2'd3}) begin
                    errors++; $display("FAIL frame_flags cyc%0d: got fs/fd=%b expected %b", i, {o_fs, o_fd}, {exp_ch == 2'd0, exp_ch == 2'd3});
                end
                checks++;
                if (o_data !== DW'(8'h40 + n_str)) begin errors++; $display("FAIL frame_data cyc%0d: got %h expected %h", i, o_data, DW'(8'h40 + n_str)); end
                if (o_fs) begin
                    if (first_fs < 0) first_fs = i;
                    else if (second_fs < 0) second_fs = i;
                end
                if (o_fd && first_fd < 0) first_fd = i;
                n_str++;
                exp_ch = exp_ch + 2'd1;
            end
        end
        checks++;
        if (first_rdy != 1) begin errors++; $display("FAIL first_ready: got cycle %0d expected 1", first_rdy); end
        checks++;
        if (first_fs != 2 || first_fd != 5) begin errors++; $display("FAIL frame_span: got start %0d done %0d expected 2/5", first_fs, first_fd); end
        checks++;
        if (second_fs - first_fs != 10) begin errors++; $display("FAIL frame_spacing: got %0d expected 10", second_fs - first_fs); end
        checks++;
        if (n_str != 11) begin errors++; $display("FAIL frame_count: got %0d strobes expected 11", n_str); end
        checks++;
        if (saw_ovr !== 1'b0) begin errors++; $display("FAIL frame_overrun: got 1 expected 0"); end
    endtask

    task automatic test_gaps();
        logic [1:0] exp_ch;
        logic exp_en;
        start_test(16'd9);
        run = 1'b1;
        exp_ch = 2'd0;
        for (int i = 0; i <= 12; i++) begin
            s_valid = (i % 2 == 0);
            cyc();
            exp_en = (i == 3 || i == 5 || i == 7 || i == 9);
            checks++;
            if (o_en !== exp_en) begin errors++; $display("FAIL gaps_en cyc%0d: got %0b expected %0b", i, o_en, exp_en); end
            if (o_en) begin
                checks++;
                if (o_ch !== exp_ch) begin errors++; $display("FAIL gaps_ch cyc%0d: got %0d expected %0d", i, o_ch, exp_ch); end
                exp_ch = exp_ch + 2'd1;
            end
        end
        checks++;
        if (exp_ch !== 2'd0) begin errors++; $display("FAIL gaps_total: got next ch %0d expected 0", exp_ch); end
    endtask

    task automatic test_overrun();
        logic exp_ovr;
        start_test(16'd2);
        run = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            overrun_clr = (i == 9 || i == 11);
            cyc();
            exp_ovr = (i >= 4 && i <= 11) || (i == 16);
            checks++;
            if (o_ovr !== exp_ovr) begin errors++; $display("FAIL overrun cyc%0d: got %0b expected %0b", i, o_ovr, exp_ovr); end
        end
        overrun_clr = 1'b0;
    endtask

    task automatic test_stop();
        logic exp_en, exp_act;
        start_test(16'd9);
        run = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) run = 1'b0;
            cyc();
            exp_en  = (i >= 2 && i <= 5);
            exp_act = (i >= 1 && i <= 4);
            checks++;
            if ({o_en, o_ready, o_busy} !== {exp_en, exp_act, exp_act}) begin
                errors++; $display("FAIL stop cyc%0d: got en/ready/busy=%b expected %b", i, {o_en, o_ready, o_busy}, {exp_en, exp_act, exp_act});
            end
            if (exp_en) begin
                checks++;
                if (o_ch !== 2'(i - 2)) begin errors++; $display("FAIL stop_ch cyc%0d: got %0d expected %0d", i, o_ch, i - 2); end
            end
        end
    endtask

    task automatic test_reset_mid();
        start_test(16'd9);
        run = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            rst = (i >= 4 && i <= 6);
            cyc();
            if (i == 4) begin
                checks++;
                if ({o_en, o_ch} !== 3'b110) begin errors++; $display("FAIL rstmid_pre cyc%0d: got en=%0b ch=%0d expected 1/2", i, o_en, o_ch); end
            end
            if (i == 5 || i == 6) begin
                checks++;
                if ({o_ready, o_en, o_fs, o_fd, o_busy, o_ovr, o_ch, o_data} !== 16'd0) begin
                    errors++; $display("FAIL rstmid_zero cyc%0d: got %b expected all 0", i, {o_ready, o_en, o_fs, o_fd, o_busy, o_ovr, o_ch, o_data});
                end
            end
            if (i == 8) begin
                checks++;
                if (o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b expected 1", o_ready); end
            end
            if (i == 9) begin
                checks++;
                if ({o_en, o_fs, o_ch} !== 4'b1100) begin errors++; $display("FAIL rstmid_restart: got en/fs/ch=%b expected 1100", {o_en, o_fs, o_ch}); end
            end
        end
    endtask

    task automatic test_back_to_back();
        start_test(16'd3);
        run = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            cyc();
            if (i >= 1) begin
                checks++;
                if ({o_ready, o_ovr} !== 2'b10) begin errors++; $display("FAIL b2b_ready cyc%0d: got ready/ovr=%b expected 10", i, {o_ready, o_ovr}); end
            end
            if (i >= 2) begin
                checks++;
                if ({o_en, o_fs, o_ch} !== {1'b1, (i - 2) % 4 == 0, 2'((i - 2) % 4)}) begin
                    errors++; $display("FAIL b2b_strobe cyc%0d: got en/fs/ch=%b expected %b", i, {o_en, o_fs, o_ch}, {1'b1, (i - 2) % 4 == 0, 2'((i - 2) % 4)});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_gaps();
        test_overrun();
        test_stop();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/emg_frame_scheduler.md
# emg_frame_scheduler

Frame-rate sequencer in front of the EMG encoding slot. On a programmable sample-period tick it pulls exactly one frame of CHANNELS samples from an upstream sample source over a valid/ready handshake. It issues them to the encoding slot as `en` strobes in strict channel order 0..CHANNELS-1, so the slot's internal multichannel delta-modulator channel counter never drifts. It also flags frame overruns and guarantees frame-atomic start/stop.

## Interface
- CHANNELS, 128, samples per frame; must be ≥2
- DW, 8, sample width (signed)
- PERIOD_W, 16, width of the period register
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = schedule frames, 0 = stop after current frame
- period  in  PERIOD_W  frame period in cycles minus 1; sampled at every frame start
- overrun_clr  in  1  pulse; clears `overrun`
- s_data  in  DW  upstream sample (signed)
- s_valid  in  1  upstream sample valid
- s_ready  out  1  scheduler accepts sample
- en_out  out  1  one-cycle strobe to slot `en`
- data_out  out  DW  sample to slot `data_in`, valid when `en_out`=1
- ch_idx  out  clogb2(CHANNELS-1)  channel of current `data_out`
- frame_start  out  1  pulse coincident with `en_out` for channel 0
- frame_done  out  1  pulse coincident with `en_out` for channel CHANNELS-1
- busy  out  1  state ≠ IDLE
- overrun  out  1  sticky: a period tick fell inside a streaming frame

## Operation
- States: IDLE, STREAM, WAIT.
- IDLE:
  - `s_ready`=0; timer held at 0.
  - `run`=1 → STREAM next cycle, timer cleared, `period` latched.
- STREAM:
  - `s_ready`=1; each handshake (`s_valid`&`s_ready`) transfers one sample and increments the channel counter.
  - No handshake → no strobe; gaps are allowed, skipped channels are not.
  - Accepting channel CHANNELS-1 ends the frame:
    - timer == latched period on that cycle → STREAM again (back-to-back frame, timer cleared, period relatched, no overrun);
    - else `run`=1 → WAIT;
    - else → IDLE.
- WAIT:
  - `s_ready`=0.
  - Timer == latched period → STREAM, timer cleared, period relatched.
  - `run`=0 → IDLE immediately.
- Timer:
  - Increments every cycle in STREAM/WAIT; cleared at each frame start.
  - Width PERIOD_W; it cannot pass the latched period because a tick always clears or consumes it.
- Overrun:
  - In STREAM, timer == latched period and the current cycle does not accept channel CHANNELS-1 → `overrun` set, timer cleared, tick dropped, frame continues.
  - Set and `overrun_clr` in the same cycle → set wins.
- `run` deasserted mid-frame: the frame completes fully (all CHANNELS samples), then IDLE. Frames are never truncated.
- `period`=0 with CHANNELS ≥ 2: every frame reports overrun; scheduling continues.
- Channel counter wraps to 0 after CHANNELS-1; CHANNELS need not be a power of two.

## Timing
- `s_ready` is a registered function of state only; it does not depend on `s_valid`.
- `en_out`, `data_out`, `ch_idx`, `frame_start`, `frame_done` are registered: asserted the cycle after the handshake (latency 1).
- `busy` and `overrun` are registered.
- First `s_ready` comes 1 cycle after `run` rises in IDLE.
- Frame-start spacing with upstream always valid and period P ≥ CHANNELS: exactly P+1 cycles.
- Reset (any state, including mid-frame): state IDLE, timer 0, channel counter 0, period register 0. All outputs 0, including `s_ready`, `en_out`, `data_out`, `ch_idx`, `frame_start`, `frame_done`, `busy` and `overrun`. Reset wins over every other input.

## Structure
- Shared package holds: state encoding constants (IDLE/STREAM/WAIT), the `clogb2` function, default CHANNELS/DW.
- One sub-module: `period_timer` (counter, clear, compare-equal output), reusable by other slot schedulers.
- The encoding slot is instantiated by the parent, not inside this block.

## Test plan
- CHANNELS=4, period=9, `s_valid` held 1, `run`=1:
  - `en_out` on 4 consecutive cycles with `ch_idx` 0,1,2,3;
  - `frame_start` on ch0, `frame_done` on ch3;
  - next `frame_start` exactly 10 cycles after the previous one;
  - `overrun`=0.
- Same setup with `s_valid` toggling 1,0,1,0: strobes only on valid cycles, `ch_idx` still 0..3 contiguous, no channel skipped.
- period=2, CHANNELS=4: `overrun` rises during the first frame and stays set; `overrun_clr` pulse coincident with the next tick → `overrun` remains 1.
- `run` dropped after ch1 accepted: ch2, ch3 still issued, then `busy`=0 and no further `s_ready`.
- `rst` asserted mid-frame at ch2, then `run`: all outputs 0 during reset; the new frame starts at `ch_idx`=0.
- period=3 (P+1 == CHANNELS), `s_valid`=1: back-to-back frames with no WAIT cycle, `overrun`=0, `s_ready` continuously 1.
